// File: rtl/fifo_stream_reader.sv
// Read-side companion for a first-word-fall-through FIFO: pops entries into a
// 2-entry skid buffer and presents them on a registered valid/ready stream.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  words_dropped
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop;
  logic                  hs;
  logic                  flush_entry;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic; a flush request while already flushing is ignored
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (fifo_empty) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Per-cycle controls; flush entry suppresses both pop and handshake
  always_comb begin
    pop         = 1'b0;
    hs          = 1'b0;
    flush_entry = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (flush) begin
            flush_entry = 1'b1;
          end else begin
            pop = enable & ~fifo_empty & (occ != 2'd2);
            hs  = m_valid & m_ready;
          end
        end
        FLUSH:   pop = ~fifo_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  assign fifo_rd_en = pop;
  assign flush_busy = (state == FLUSH);

  // Skid buffer, stream outputs and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      occ           <= 2'd0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      skid_data     <= '0;
      flush_done    <= 1'b0;
      words_out     <= '0;
      words_dropped <= '0;
    end else begin
      flush_done <= (state == FLUSH) & fifo_empty;
      if (hs) words_out <= words_out + CNT_WIDTH'(1);
      if (flush_entry)
        words_dropped <= words_dropped + CNT_WIDTH'(occ);
      else if (state == FLUSH && pop)
        words_dropped <= words_dropped + CNT_WIDTH'(1);

      if (flush_entry) begin
        occ     <= 2'd0;
        m_valid <= 1'b0;
      end else if (state == RUN) begin
        unique case (occ)
          2'd0: if (pop) begin
            m_data  <= fifo_data;
            m_valid <= 1'b1;
            occ     <= 2'd1;
          end
          2'd1: begin
            if (pop && hs) begin
              m_data <= fifo_data;
            end else if (pop) begin
              skid_data <= fifo_data;
              occ       <= 2'd2;
            end else if (hs) begin
              m_valid <= 1'b0;
              occ     <= 2'd0;
            end
          end
          2'd2: if (hs) begin
            m_data <= skid_data;
            occ    <= 2'd1;
          end
          default: occ <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion to the team's synchronous first-word-fall-through FIFO: pops entries and presents them downstream on a registered valid/ready stream.
- Holds a 2-entry output skid buffer, so full throughput is kept with registered outputs.
- Supports pause (enable), a flush that discards queued entries, and wrap-around statistics counters.
- Sits between request FIFOs and the hash-table lookup/insert pipelines.

Parameters:
- DATA_WIDTH, 8, width of FIFO entries and m_data.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; 1 = pop FIFO and forward, 0 = pause new pops.
- flush  input  1  single-cycle request to discard buffered and queued entries.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_rd_en  output  1  pop strobe to FIFO, combinational.
- m_valid  output  1  downstream data valid, registered.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  downstream data, registered.
- flush_busy  output  1  high while in FLUSH state.
- flush_done  output  1  one-cycle pulse when a flush completes.
- words_out  output  CNT_WIDTH  count of completed downstream handshakes.
- words_dropped  output  CNT_WIDTH  count of entries discarded by flush.

Behaviour:
- Reset values: m_valid=0, m_data=0, flush_busy=0, flush_done=0, words_out=0, words_dropped=0, occupancy=0, state RUN.
- Reset applies mid-flush or mid-transfer: buffers are emptied with no flush_done pulse.
- FSM has two states, RUN and FLUSH.
- RUN→FLUSH when flush=1. This takes priority over enable, m_ready and pop in that cycle.
- FLUSH→RUN in the first cycle fifo_empty=1 while in FLUSH; flush_done=1 in the following cycle.
- flush asserted while already in FLUSH is ignored.
- Skid buffer: main register drives m_data/m_valid; the skid register holds the second-oldest word. Occupancy is 0..2; m_valid = (occ>=1).
- RUN pop rule: fifo_rd_en = enable & !fifo_empty & (occ<2).
  - fifo_rd_en is never asserted while fifo_empty=1, because the FIFO mishandles a simultaneous read and write when empty.
- Handshake occurs when m_valid & m_ready.
- RUN update per cycle, by occupancy, pop (P) and handshake (H):
  - occ0 + P: fifo_data→main, occ=1.
  - occ1 + P + H: fifo_data→main, occ stays 1.
  - occ1 + P only: fifo_data→skid, occ=2.
  - occ1 + H only: occ=0.
  - occ2 + H: skid→main, occ=1 (no pop possible at occ2).
- Ordering is strict FIFO order; no word is duplicated or lost outside flush.
- Latency: a word at the FIFO head with occ=0 and enable=1 is popped in cycle N and appears with m_valid=1 in cycle N+1.
- Sustained throughput is 1 word/cycle when m_ready=1.
- Once asserted, m_valid/m_data hold stable until handshake. The sole exception is flush, which drops m_valid the next cycle.
- enable=0 stops new pops only; words already buffered are still delivered.
- m_data holds its last value when m_valid=0.
- Flush entry cycle: occupancy is cleared, words_dropped += occ, and no handshake or pop is performed.
- In FLUSH: m_valid=0, fifo_rd_en = !fifo_empty, and each pop does words_dropped += 1.
  - A writer still filling the FIFO extends the flush.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- At flush entry the drop increment is occ (0..2), computed in CNT_WIDTH arithmetic.

Test Plan:
- Stream: FIFO preloaded 0x11,0x22,0x33, enable=1, m_ready=1 → fifo_rd_en high 3 cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after first pop; words_out=3.
- Backpressure: 4 words queued, m_ready=0 → exactly 2 pops, then fifo_rd_en=0 with m_data=first word held stable. Raise m_ready → all 4 delivered in order with no gap.
- Pause: enable=0 with occ=1 and 3 words queued → buffered word delivered, no pops. enable=1 → remaining 3 words follow.
- Flush: occ=2, 5 words queued, flush pulse → m_valid=0 next cycle, 5 pops, flush_busy high until fifo_empty=1, single flush_done pulse, words_dropped=7.
- Empty safety: fifo_empty=1 for 20 cycles including during FLUSH → fifo_rd_en never asserted; flush completes with words_dropped unchanged.
- Wrap/reset: CNT_WIDTH=4, 17 handshakes → words_out=1. Reset mid-flush → all outputs at reset values, no flush_done.
